// File: rtl/t_stream_buffer.sv
// SRAM-backed circular store for the T sequence; loads T from the host, then serves in-order reads/write-backs.
// Read latency 1 cycle; load backpressure via o_load_ready. Optional pass counter under TSTREAM_PASS_CNT_EN.
module t_stream_buffer #(
  parameter int VEF_W  = 16,
  parameter int WORD_W = 2 + 2 * VEF_W,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_load_valid,
  input  logic [1:0]        i_load_t,
  input  logic              i_load_last,
  output logic              o_load_ready,
  input  logic              i_sram_request,
  output logic [WORD_W-1:0] o_request_data,
  input  logic              i_sram_send,
  input  logic [WORD_W-1:0] i_send_data,
  output logic [ADDR_W:0]   o_T_size,
  output logic              o_run,
`ifdef TSTREAM_PASS_CNT_EN
  output logic [15:0]       o_pass_cnt,
`endif
  output logic              o_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PINC_C  = ADDR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     pending_q, pending_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W:0]     t_size_q, t_size_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
`ifdef TSTREAM_PASS_CNT_EN
  logic [15:0]         pass_cnt_q, pass_cnt_d;
`endif

  logic [WORD_W-1:0]   mem [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [WORD_W-1:0]   mem_wdata;

  logic                load_ready;
  logic                load_acc;
  logic                run;
  logic                req;
  logic                snd_ok;
  logic                rd_last;
  logic                wr_last;

  assign run        = (state_q == S_RUN);
  assign load_ready = !run && (count_q != DEPTH_C);
  assign load_acc   = i_load_valid && load_ready;
  assign req        = run && i_sram_request;
  // A send alongside a request is always legal; alone it needs something outstanding.
  assign snd_ok     = run && i_sram_send && (i_sram_request || (pending_q != '0));
  assign rd_last    = ({1'b0, rd_ptr_q} == (t_size_q - ONE_C));
  assign wr_last    = ({1'b0, wr_ptr_q} == (t_size_q - ONE_C));

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    pending_d  = pending_q;
    count_d    = count_q;
    t_size_d   = t_size_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
`ifdef TSTREAM_PASS_CNT_EN
    pass_cnt_d = pass_cnt_q;
`endif
    mem_we     = 1'b0;
    mem_waddr  = wr_ptr_q;
    mem_wdata  = {i_load_t, {(2 * VEF_W){1'b0}}};

    case (state_q)
      S_IDLE, S_LOAD: begin
        if (load_acc) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PINC_C;
          count_d  = count_q + ONE_C;
          if (!i_load_last && (count_q == DEPTH_C - ONE_C)) err_d = 1'b1;
        end
        // A last beat arriving after the store filled up still closes the load.
        if (i_load_valid && i_load_last) begin
          state_d   = S_RUN;
          t_size_d  = load_acc ? count_q + ONE_C : count_q;
          rd_ptr_d  = '0;
          wr_ptr_d  = '0;
          pending_d = '0;
        end else if (load_acc) begin
          state_d = S_LOAD;
        end
      end
      S_RUN: begin
        if (req) begin
          rdata_d  = (snd_ok && (rd_ptr_q == wr_ptr_q)) ? i_send_data : mem[rd_ptr_q];
          rd_ptr_d = rd_last ? '0 : rd_ptr_q + PINC_C;
`ifdef TSTREAM_PASS_CNT_EN
          if (rd_last && (pass_cnt_q != 16'hFFFF)) pass_cnt_d = pass_cnt_q + 16'd1;
`endif
        end
        if (snd_ok) begin
          mem_we    = 1'b1;
          mem_wdata = i_send_data;
          wr_ptr_d  = wr_last ? '0 : wr_ptr_q + PINC_C;
        end
        case ({i_sram_request, i_sram_send})
          2'b10: begin
            if (pending_q == t_size_q) err_d = 1'b1;
            else pending_d = pending_q + ONE_C;
          end
          2'b01: begin
            if (pending_q == '0) err_d = 1'b1;
            else pending_d = pending_q - ONE_C;
          end
          default: pending_d = pending_q;
        endcase
      end
      default: state_d = S_IDLE;
    endcase

    if (i_clear) begin
      state_d    = S_IDLE;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      pending_d  = '0;
      count_d    = '0;
      t_size_d   = '0;
      rdata_d    = '0;
      err_d      = 1'b0;
`ifdef TSTREAM_PASS_CNT_EN
      pass_cnt_d = '0;
`endif
      mem_we     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      pending_q  <= '0;
      count_q    <= '0;
      t_size_q   <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
`ifdef TSTREAM_PASS_CNT_EN
      pass_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      pending_q  <= pending_d;
      count_q    <= count_d;
      t_size_q   <= t_size_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
`ifdef TSTREAM_PASS_CNT_EN
      pass_cnt_q <= pass_cnt_d;
`endif
    end
  end

  // Storage is deliberately not reset; contents survive i_clear.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign o_load_ready   = load_ready;
  assign o_request_data = rdata_q;
  assign o_T_size       = t_size_q;
  assign o_run          = run;
  assign o_err          = err_q;
`ifdef TSTREAM_PASS_CNT_EN
  assign o_pass_cnt     = pass_cnt_q;
`endif

endmodule

// File: tb/tb_t_stream_buffer.sv
// Scoreboard bench for t_stream_buffer: expected read words are queued when a request is driven.
module tb_t_stream_buffer;
  localparam int VEF_W  = 16;
  localparam int WORD_W = 2 + 2 * VEF_W;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_clear;
  logic              i_load_valid;
  logic [1:0]        i_load_t;
  logic              i_load_last;
  logic              o_load_ready;
  logic              i_sram_request;
  logic [WORD_W-1:0] o_request_data;
  logic              i_sram_send;
  logic [WORD_W-1:0] i_send_data;
  logic [ADDR_W:0]   o_T_size;
  logic              o_run;
  logic              o_err;
`ifdef TSTREAM_PASS_CNT_EN
  logic [15:0]       o_pass_cnt;
`endif

  t_stream_buffer #(.VEF_W(VEF_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_clear        (i_clear),
    .i_load_valid   (i_load_valid),
    .i_load_t       (i_load_t),
    .i_load_last    (i_load_last),
    .o_load_ready   (o_load_ready),
    .i_sram_request (i_sram_request),
    .o_request_data (o_request_data),
    .i_sram_send    (i_sram_send),
    .i_send_data    (i_send_data),
    .o_T_size       (o_T_size),
    .o_run          (o_run),
`ifdef TSTREAM_PASS_CNT_EN
    .o_pass_cnt     (o_pass_cnt),
`endif
    .o_err          (o_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [WORD_W-1:0] mm [DEPTH];
  logic [WORD_W-1:0] exp_q [$];
  logic [WORD_W-1:0] last_rd;
  int  m_rd, m_wr, m_pend, m_size, m_cnt, m_pass;
  bit  m_run;
  logic exp_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_rd = 0; m_wr = 0; m_pend = 0; m_size = 0; m_cnt = 0; m_pass = 0;
    m_run = 0; exp_err = 1'b0; last_rd = '0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rdy"},   o_load_ready, 1);
    chk({tag, "_rdata"}, o_request_data, 0);
    chk({tag, "_tsize"}, o_T_size, 0);
    chk({tag, "_run"},   o_run, 0);
    chk({tag, "_err"},   o_err, 0);
`ifdef TSTREAM_PASS_CNT_EN
    chk({tag, "_pass"},  o_pass_cnt, 0);
`endif
  endtask

  task automatic load_beat(input logic [1:0] t, input bit last);
    i_load_valid = 1'b1; i_load_t = t; i_load_last = last;
    if (!m_run) begin
      if (m_cnt < DEPTH) begin
        mm[m_cnt] = {t, 32'h0};
        m_cnt++;
        if (!last && m_cnt == DEPTH) exp_err = 1'b1;
      end
      if (last) begin
        m_run = 1; m_size = m_cnt; m_rd = 0; m_wr = 0; m_pend = 0;
      end
    end
    @(posedge clk); #1;
    i_load_valid = 1'b0; i_load_last = 1'b0;
    chk("load_rdy", o_load_ready, (!m_run && m_cnt < DEPTH));
    chk("load_run", o_run, m_run);
    chk("load_tsize", o_T_size, m_run ? m_size : 0);
    chk("load_err", o_err, exp_err);
  endtask

  task automatic cycle(input bit req, input bit snd, input logic [WORD_W-1:0] sd);
    logic [WORD_W-1:0] e;
    i_sram_request = req; i_sram_send = snd; i_send_data = sd;
    if (req) begin
      e = (snd && m_rd == m_wr) ? sd : mm[m_rd];
      exp_q.push_back(e);
      if (m_rd == m_size - 1 && m_pass < 65535) m_pass++;
    end
    if (snd && (req || m_pend != 0)) begin
      mm[m_wr] = sd;
      m_wr = (m_wr + 1) % m_size;
    end
    if (req) m_rd = (m_rd + 1) % m_size;
    if (req && !snd) begin
      if (m_pend == m_size) exp_err = 1'b1; else m_pend++;
    end else if (snd && !req) begin
      if (m_pend == 0) exp_err = 1'b1; else m_pend--;
    end
    @(posedge clk); #1;
    i_sram_request = 1'b0; i_sram_send = 1'b0;
    if (req) begin
      last_rd = exp_q.pop_front();
      chk("rdata", o_request_data, last_rd);
    end else begin
      chk("rdata_hold", o_request_data, last_rd);
    end
    chk("run_err", o_err, exp_err);
  endtask

  task automatic do_clear();
    i_clear = 1'b1; i_sram_request = 1'b1;
    @(posedge clk); #1;
    i_clear = 1'b0; i_sram_request = 1'b0;
    model_reset();
    check_reset("clear");
  endtask

  initial begin
    rst_n = 1'b0; i_clear = 1'b0; i_load_valid = 1'b0; i_load_t = 2'd0; i_load_last = 1'b0;
    i_sram_request = 1'b0; i_sram_send = 1'b0; i_send_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;

    // Load 0..3, read them back
    for (int i = 0; i < 4; i++) load_beat(2'(i), i == 3);
    for (int i = 0; i < 4; i++) cycle(1, 0, '0);
    cycle(0, 0, '0);

    // Write back A..D, read again across the wrap
    for (int i = 0; i < 4; i++) cycle(0, 1, WORD_W'(10 + i));
    for (int i = 0; i < 4; i++) cycle(1, 0, '0);

    // Write-first at pending==size, then an over-read
    cycle(1, 1, WORD_W'(8'h55));
    cycle(1, 0, '0);

    // Under-write leaves memory untouched
    do_clear();
    for (int i = 0; i < 4; i++) load_beat(2'(3 - i), i == 3);
    cycle(0, 1, WORD_W'(8'h77));
    for (int i = 0; i < 4; i++) cycle(1, 0, '0);

    // Overfill without last, then a late last
    do_clear();
    for (int i = 0; i < DEPTH; i++) load_beat(2'(i % 4), 1'b0);
    load_beat(2'd2, 1'b1);
    cycle(1, 0, '0);
    cycle(1, 0, '0);

    // Short reload after clear
    do_clear();
    load_beat(2'd1, 1'b0);
    load_beat(2'd2, 1'b1);
    cycle(1, 0, '0);
    cycle(1, 0, '0);

    // Three passes over a 3-element T
    do_clear();
    for (int i = 0; i < 3; i++) load_beat(2'(i), i == 2);
    for (int i = 0; i < 9; i++) cycle(1, i > 0, WORD_W'(100 + i));
`ifdef TSTREAM_PASS_CNT_EN
    chk("pass_cnt", o_pass_cnt, m_pass);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
